// File: rtl/log_arbiter.sv
// Round-robin event-log arbiter: severity filter, timestamping and an output FIFO toward one sink.
// Optional FATAL drain-and-halt behaviour is enabled by defining LOG_ARBITER_FATAL_HALT_EN.
module log_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int TS_W      = 32,
  parameter int DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [3*NUM_SRC-1:0]           src_level,
  input  logic [PAYLOAD_W*NUM_SRC-1:0]   src_payload,
  input  logic [2:0]                     min_level,
  output logic                           log_valid,
  input  logic                           log_ready,
  output logic [$clog2(NUM_SRC)-1:0]     log_src,
  output logic [2:0]                     log_level,
  output logic [PAYLOAD_W-1:0]           log_payload,
  output logic [TS_W-1:0]                log_timestamp,
  output logic [15:0]                    filtered_count,
  output logic                           halt
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  function automatic logic [2:0] eff_level(input logic [2:0] lvl);
    return (lvl > 3'd5) ? 3'd2 : lvl;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SRC_W-1:0]     rr;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 grant_en;
  logic                 run_en;
  logic [2:0]           sel_lvl;
  logic [PAYLOAD_W-1:0] sel_pay;
  logic                 push;
  logic                 pop;
  logic [TS_W-1:0]      ts;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic [SRC_W-1:0]     mem_src [DEPTH];
  logic [2:0]           mem_lvl [DEPTH];
  logic [PAYLOAD_W-1:0] mem_pay [DEPTH];
  logic [TS_W-1:0]      mem_ts  [DEPTH];

  // Grants are withheld during reset so src_ready reads zero while rst_n is low.
  assign grant_en = rst_n && run_en && (count < DEPTH_C);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!gnt_vld && src_valid[idx[SRC_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SRC_W-1:0];
      end
    end
    gnt_vld = gnt_vld && grant_en;
  end

  always_comb begin
    src_ready = '0;
    if (gnt_vld) src_ready[gnt_idx] = 1'b1;
  end

  assign sel_lvl = eff_level(src_level[int'(gnt_idx)*3 +: 3]);
  assign sel_pay = src_payload[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];
  assign push    = gnt_vld && (sel_lvl >= min_level);
  assign pop     = (count != '0) && log_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr             <= '0;
      ts             <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      filtered_count <= '0;
    end else begin
      ts    <= ts + 1'b1;
      count <= count_next;
      if (gnt_vld) rr <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
      if (gnt_vld && !push) filtered_count <= sat_inc16(filtered_count);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wr_ptr] <= gnt_idx;
      mem_lvl[wr_ptr] <= sel_lvl;
      mem_pay[wr_ptr] <= sel_pay;
      mem_ts[wr_ptr]  <= ts;
    end
  end

  assign log_valid     = (count != '0);
  assign log_src       = log_valid ? mem_src[rd_ptr] : '0;
  assign log_level     = log_valid ? mem_lvl[rd_ptr] : '0;
  assign log_payload   = log_valid ? mem_pay[rd_ptr] : '0;
  assign log_timestamp = log_valid ? mem_ts[rd_ptr]  : '0;

`ifdef LOG_ARBITER_FATAL_HALT_EN
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;
  logic   halt_r;

  // HALTED is entered as soon as the FIFO is known to be empty next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halt_r <= 1'b0;
    end else begin
      case (state)
        RUN:     if (push && sel_lvl == 3'd5) state <= DRAIN;
        DRAIN:   if (count_next == '0) begin
                   state  <= HALTED;
                   halt_r <= 1'b1;
                 end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign run_en = (state == RUN);
  assign halt   = halt_r;
`else
  assign run_en = 1'b1;
  assign halt   = 1'b0;
`endif

endmodule

// File: tb/tb_log_arbiter.sv
// Directed bench for log_arbiter (NUM_SRC=4, DEPTH=4, TS_W=4 so timestamp wrap is reachable).
module tb_log_arbiter;

  localparam int NS = 4;
  localparam int PW = 32;
  localparam int TW = 4;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [3*NS-1:0]   src_level;
  logic [PW*NS-1:0]  src_payload;
  logic [2:0]        min_level;
  logic              log_valid;
  logic              log_ready;
  logic [1:0]        log_src;
  logic [2:0]        log_level;
  logic [PW-1:0]     log_payload;
  logic [TW-1:0]     log_timestamp;
  logic [15:0]       filtered_count;
  logic              halt;

  int total = 0;
  int bad   = 0;

  log_arbiter #(.NUM_SRC(NS), .PAYLOAD_W(PW), .TS_W(TW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_level(src_level), .src_payload(src_payload),
    .min_level(min_level),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_src(log_src), .log_level(log_level),
    .log_payload(log_payload), .log_timestamp(log_timestamp),
    .filtered_count(filtered_count), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [2:0] lv, input logic [31:0] p);
    src_valid[i]          = v;
    src_level[i*3 +: 3]   = lv;
    src_payload[i*32 +: 32] = p;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    src_valid   = '0;
    src_level   = '0;
    src_payload = '0;
    log_ready   = 1'b0;
    min_level   = 3'd0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    src_valid   = '1;
    src_level   = '0;
    src_payload = '1;
    log_ready   = 1'b1;
    min_level   = 3'd0;
    #2;
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL reset_src_ready got=%b exp=0000", src_ready); end
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL reset_log_valid got=%b exp=0", log_valid); end
    total++; if (log_payload !== 32'h0) begin bad++; $display("FAIL reset_log_payload got=%h exp=0", log_payload); end
    total++; if (log_timestamp !== 4'h0) begin bad++; $display("FAIL reset_log_ts got=%h exp=0", log_timestamp); end
    total++; if (filtered_count !== 16'h0) begin bad++; $display("FAIL reset_filtered got=%h exp=0", filtered_count); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", halt); end
    do_reset;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    do_reset;
    log_ready = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 3'd2, 32'hA0 + i);
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      total++; if (src_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, src_ready, exp_rdy); end
      if (k > 0) begin
        total++; if (log_valid !== 1'b1) begin bad++; $display("FAIL rr_log_valid k=%0d got=%b exp=1", k, log_valid); end
        total++; if (log_src !== 2'((k - 1) % 4)) begin bad++; $display("FAIL rr_log_src k=%0d got=%0d exp=%0d", k, log_src, (k - 1) % 4); end
        total++; if (log_timestamp !== 4'(k - 1)) begin bad++; $display("FAIL rr_log_ts k=%0d got=%0d exp=%0d", k, log_timestamp, k - 1); end
        total++; if (log_payload !== 32'hA0 + 32'((k - 1) % 4)) begin bad++; $display("FAIL rr_log_payload k=%0d got=%h", k, log_payload); end
      end
      tick;
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] heads [6];
    logic [3:0]  exp_rdy;
    heads = '{32'h100, 32'h300, 32'h100, 32'h300, 32'h100, 32'h300};
    do_reset;
    set_src(0, 1'b1, 3'd3, 32'h100);
    set_src(2, 1'b1, 3'd3, 32'h300);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      total++; if (src_ready !== exp_rdy) begin bad++; $display("FAIL bp_fill k=%0d got=%b exp=%b", k, src_ready, exp_rdy); end
      tick;
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_ready k=%0d got=%b exp=0000", k, src_ready); end
      total++; if (log_payload !== 32'h100) begin bad++; $display("FAIL bp_full_head k=%0d got=%h exp=100", k, log_payload); end
      tick;
      #1;
    end
    log_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k == 0) ? 4'b0000 : ((k % 2 == 1) ? 4'b0001 : 4'b0100);
      total++; if (log_payload !== heads[k]) begin bad++; $display("FAIL bp_pop_head k=%0d got=%h exp=%h", k, log_payload, heads[k]); end
      total++; if (src_ready !== exp_rdy) begin bad++; $display("FAIL bp_pop_grant k=%0d got=%b exp=%b", k, src_ready, exp_rdy); end
      tick;
      #1;
    end
  endtask

  task automatic test_filter;
    do_reset;
    min_level = 3'd3;
    set_src(1, 1'b1, 3'd1, 32'h11);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("FAIL filt_debug_grant got=%b exp=0010", src_ready); end
    tick;
    #1;
    total++; if (filtered_count !== 16'd1) begin bad++; $display("FAIL filt_debug_count got=%0d exp=1", filtered_count); end
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL filt_debug_queued got=%b exp=0", log_valid); end
    set_src(1, 1'b1, 3'd4, 32'h22);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("FAIL filt_error_grant got=%b exp=0010", src_ready); end
    tick;
    #1;
    total++; if (log_valid !== 1'b1) begin bad++; $display("FAIL filt_error_valid got=%b exp=1", log_valid); end
    total++; if (log_level !== 3'd4) begin bad++; $display("FAIL filt_error_level got=%0d exp=4", log_level); end
    total++; if (log_src !== 2'd1) begin bad++; $display("FAIL filt_error_src got=%0d exp=1", log_src); end
    total++; if (log_payload !== 32'h22) begin bad++; $display("FAIL filt_error_payload got=%h exp=22", log_payload); end
    set_src(1, 1'b1, 3'd7, 32'h33);
    #1;
    tick;
    #1;
    total++; if (filtered_count !== 16'd2) begin bad++; $display("FAIL filt_code7_count got=%0d exp=2", filtered_count); end
    min_level = 3'd2;
    set_src(1, 1'b1, 3'd6, 32'h44);
    #1;
    tick;
    #1;
    total++; if (filtered_count !== 16'd2) begin bad++; $display("FAIL filt_code6_count got=%0d exp=2", filtered_count); end
    min_level = 3'd6;
    set_src(1, 1'b1, 3'd5, 32'h55);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("FAIL filt_fatal_grant got=%b exp=0010", src_ready); end
    tick;
    #1;
    total++; if (filtered_count !== 16'd3) begin bad++; $display("FAIL filt_fatal_count got=%0d exp=3", filtered_count); end
    set_src(1, 1'b1, 3'd2, 32'h66);
    #1;
    total++; if (src_ready !== 4'b0010) begin bad++; $display("FAIL filt_after_fatal_grant got=%b exp=0010", src_ready); end
    tick;
    set_src(1, 1'b0, 3'd2, 32'h66);
    log_ready = 1'b1;
    #1;
    total++; if (filtered_count !== 16'd4) begin bad++; $display("FAIL filt_after_fatal_count got=%0d exp=4", filtered_count); end
    tick;
    #1;
    total++; if (log_payload !== 32'h44) begin bad++; $display("FAIL filt_code6_payload got=%h exp=44", log_payload); end
    total++; if (log_level !== 3'd2) begin bad++; $display("FAIL filt_code6_level got=%0d exp=2", log_level); end
    tick;
    #1;
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL filt_drained got=%b exp=0", log_valid); end
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL filt_halt got=%b exp=0", halt); end
  endtask

  task automatic test_saturation;
    do_reset;
    min_level = 3'd7;
    log_ready = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 3'd0, 32'h0);
    #1;
    for (int n = 1; n <= 65540; n++) begin
      tick;
      if (n == 10) begin
        total++; if (filtered_count !== 16'd10) begin bad++; $display("FAIL sat_early got=%0d exp=10", filtered_count); end
      end
      if (n == 65534) begin
        total++; if (filtered_count !== 16'hFFFE) begin bad++; $display("FAIL sat_near got=%h exp=fffe", filtered_count); end
      end
    end
    total++; if (filtered_count !== 16'hFFFF) begin bad++; $display("FAIL sat_final got=%h exp=ffff", filtered_count); end
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL sat_log_valid got=%b exp=0", log_valid); end
  endtask

  task automatic test_ts_wrap;
    do_reset;
    log_ready = 1'b1;
    set_src(3, 1'b1, 3'd2, 32'h77);
    #1;
    for (int k = 1; k <= 18; k++) begin
      tick;
      #1;
      total++; if (log_timestamp !== 4'((k - 1) % 16)) begin bad++; $display("FAIL ts_wrap k=%0d got=%0d exp=%0d", k, log_timestamp, (k - 1) % 16); end
    end
  endtask

  task automatic test_fatal;
    do_reset;
    set_src(0, 1'b1, 3'd2, 32'd1);
    #1;
    tick;
    set_src(0, 1'b1, 3'd2, 32'd2);
    #1;
    tick;
    set_src(0, 1'b1, 3'd5, 32'd3);
    #1;
    tick;
    set_src(0, 1'b1, 3'd2, 32'd4);
    #1;
`ifdef LOG_ARBITER_FATAL_HALT_EN
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL fatal_no_grant got=%b exp=0000", src_ready); end
    tick;
    #1;
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL fatal_no_grant2 got=%b exp=0000", src_ready); end
    log_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (log_payload !== 32'(k + 1)) begin bad++; $display("FAIL fatal_pop k=%0d got=%0d exp=%0d", k, log_payload, k + 1); end
      total++; if (halt !== 1'b0) begin bad++; $display("FAIL fatal_early_halt k=%0d got=%b exp=0", k, halt); end
      tick;
      #1;
    end
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL fatal_halt_rise got=%b exp=1", halt); end
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL fatal_empty got=%b exp=0", log_valid); end
    tick;
    tick;
    #1;
    total++; if (halt !== 1'b1) begin bad++; $display("FAIL fatal_halt_hold got=%b exp=1", halt); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL fatal_halted_grant got=%b exp=0000", src_ready); end
`else
    total++; if (src_ready !== 4'b0001) begin bad++; $display("FAIL fatal_off_grant got=%b exp=0001", src_ready); end
    tick;
    set_src(0, 1'b0, 3'd2, 32'd4);
    log_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (log_payload !== 32'(k + 1)) begin bad++; $display("FAIL fatal_off_pop k=%0d got=%0d exp=%0d", k, log_payload, k + 1); end
      total++; if (halt !== 1'b0) begin bad++; $display("FAIL fatal_off_halt k=%0d got=%b exp=0", k, halt); end
      tick;
      #1;
    end
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL fatal_off_empty got=%b exp=0", log_valid); end
`endif
    set_src(0, 1'b1, 3'd2, 32'd8);
    set_src(1, 1'b1, 3'd2, 32'd9);
    rst_n = 1'b0;
    #1;
    total++; if (halt !== 1'b0) begin bad++; $display("FAIL fatal_reset_halt got=%b exp=0", halt); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL fatal_reset_ready got=%b exp=0000", src_ready); end
    tick;
    rst_n = 1'b1;
    #1;
    total++; if (src_ready !== 4'b0001) begin bad++; $display("FAIL fatal_reset_rr got=%b exp=0001", src_ready); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_src(2, 1'b1, 3'd3, 32'h5A);
    #1;
    tick;
    tick;
    tick;
    set_src(2, 1'b0, 3'd3, 32'h5A);
    #1;
    total++; if (log_valid !== 1'b1) begin bad++; $display("FAIL mid_filled got=%b exp=1", log_valid); end
    total++; if (log_payload !== 32'h5A) begin bad++; $display("FAIL mid_head got=%h exp=5a", log_payload); end
    set_src(2, 1'b1, 3'd3, 32'hB0);
    rst_n = 1'b0;
    #1;
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", log_valid); end
    total++; if (log_payload !== 32'h0) begin bad++; $display("FAIL mid_async_payload got=%h exp=0", log_payload); end
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL mid_async_ready got=%b exp=0000", src_ready); end
    tick;
    tick;
    set_src(2, 1'b0, 3'd3, 32'hB0);
    rst_n = 1'b1;
    #1;
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL mid_after_release got=%b exp=0", log_valid); end
    set_src(2, 1'b1, 3'd3, 32'hC1);
    #1;
    tick;
    set_src(2, 1'b0, 3'd3, 32'hC1);
    #1;
    total++; if (log_payload !== 32'hC1) begin bad++; $display("FAIL mid_new_head got=%h exp=c1", log_payload); end
    log_ready = 1'b1;
    #1;
    tick;
    #1;
    total++; if (log_valid !== 1'b0) begin bad++; $display("FAIL mid_single_entry got=%b exp=0", log_valid); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_backpressure;
    test_filter;
    test_ts_wrap;
    test_fatal;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
